// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared FSM state, BRESP codes and width helpers
// for the DDR write arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_wr_arbiter_if.sv
// ddr_wr_arbiter_if: per-channel AXI write slave ports plus the
// single AXI write master port toward the DDR interconnect.
interface ddr_wr_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 3
);

  logic [NUM_CH-1:0]        s_axi_awvalid;
  logic [NUM_CH-1:0]        s_axi_awready;
  logic [NUM_CH*ADDR_W-1:0] s_axi_awaddr;
  logic [NUM_CH*8-1:0]      s_axi_awlen;
  logic [NUM_CH*DATA_W-1:0] s_axi_wdata;
  logic [NUM_CH-1:0]        s_axi_wvalid;
  logic [NUM_CH-1:0]        s_axi_wready;
  logic [NUM_CH-1:0]        s_axi_wlast;
  logic [NUM_CH-1:0]        s_axi_bvalid;
  logic [NUM_CH-1:0]        s_axi_bready;
  logic [NUM_CH*2-1:0]      s_axi_bresp;

  logic                     m_axi_awvalid;
  logic                     m_axi_awready;
  logic [ADDR_W-1:0]        m_axi_awaddr;
  logic [7:0]               m_axi_awlen;
  logic [ID_W-1:0]          m_axi_awid;
  logic                     m_axi_wvalid;
  logic                     m_axi_wready;
  logic [DATA_W-1:0]        m_axi_wdata;
  logic                     m_axi_wlast;
  logic [DATA_W/8-1:0]      m_axi_wstrb;
  logic                     m_axi_bvalid;
  logic                     m_axi_bready;
  logic [ID_W-1:0]          m_axi_bid;
  logic [1:0]               m_axi_bresp;

  modport slave (
    input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
    input  s_axi_wdata, s_axi_wvalid, s_axi_wlast,
    input  s_axi_bready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bvalid, s_axi_bresp,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    output m_axi_awid,
    output m_axi_wvalid, m_axi_wdata, m_axi_wlast,
    output m_axi_wstrb, m_axi_bready,
    input  m_axi_awready, m_axi_wready,
    input  m_axi_bvalid, m_axi_bid, m_axi_bresp
  );

  modport master (
    output s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
    output s_axi_wdata, s_axi_wvalid, s_axi_wlast,
    output s_axi_bready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bvalid, s_axi_bresp,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
    input  m_axi_awid,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wlast,
    input  m_axi_wstrb, m_axi_bready,
    output m_axi_awready, m_axi_wready,
    output m_axi_bvalid, m_axi_bid, m_axi_bresp
  );

endinterface

// File: rtl/ddr_rr_arbiter.sv
// ddr_rr_arbiter: combinational round-robin pick after ptr.
// DDR_ARB_PRIO_EN gives channel 0 absolute priority.
module ddr_rr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  always_comb begin
    c   = 0;
    idx = '0;
    gnt = '0;
    any = |req;
    // Walk farthest-first so the nearest requester after ptr wins.
    for (int off = N; off >= 1; off--) begin
      c = (int'(ptr) + off) % N;
      if (req[c]) idx = IW'(c);
    end
`ifdef DDR_ARB_PRIO_EN
    if (req[0]) idx = '0;
`endif
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: N-channel AXI write arbiter onto one DDR port.
// Define DDR_ARB_PRIO_EN for channel-0 priority arbitration.
module ddr_wr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 3,
  parameter int MAX_OUT = 4
) (
  input  logic             aclk,
  input  logic             areset,
  ddr_wr_arbiter_if.slave  bus,
  output logic             err
);

  localparam int IW = idx_w(NUM_CH);
  localparam int CW = cnt_w(MAX_OUT);

  state_t            state;
  state_t            state_nx;
  logic [IW-1:0]     grant;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     arb_idx;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] arb_gnt;
  logic [NUM_CH-1:0] elig;
  logic              arb_any;
  logic [7:0]        beats;
  logic [CW-1:0]     outst [NUM_CH];

  logic              aw_hs;
  logic              w_hs;
  logic              w_done;
  logic [NUM_CH-1:0] b_hs;
  logic              b_legal;

  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_len;
  logic [DATA_W-1:0] sel_data;
  logic              sel_wvalid;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = bus.s_axi_awvalid[i] &&
                (outst[i] < CW'(MAX_OUT));
    end
  end

  ddr_rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req (elig),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_addr   = '0;
    sel_len    = '0;
    sel_data   = '0;
    sel_wvalid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_oh[i]) begin
        sel_addr   = bus.s_axi_awaddr[i*ADDR_W +: ADDR_W];
        sel_len    = bus.s_axi_awlen[i*8 +: 8];
        sel_data   = bus.s_axi_wdata[i*DATA_W +: DATA_W];
        sel_wvalid = bus.s_axi_wvalid[i];
      end
    end
  end

  always_comb begin
    state_nx          = state;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.s_axi_awready = '0;
    bus.s_axi_wready  = '0;
    aw_hs             = 1'b0;
    w_hs              = 1'b0;
    w_done            = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (arb_any) state_nx = ST_ADDR;
      end
      ST_ADDR: begin
        bus.m_axi_awvalid = 1'b1;
        bus.s_axi_awready = grant_oh &
          {NUM_CH{bus.m_axi_awready}};
        aw_hs = bus.m_axi_awready;
        if (aw_hs) state_nx = ST_DATA;
      end
      ST_DATA: begin
        bus.m_axi_wvalid = sel_wvalid;
        bus.s_axi_wready = grant_oh &
          {NUM_CH{bus.m_axi_wready}};
        w_hs   = sel_wvalid && bus.m_axi_wready;
        w_done = w_hs && (beats == 8'd0);
        if (w_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.m_axi_awaddr = sel_addr;
  assign bus.m_axi_awlen  = sel_len;
  assign bus.m_axi_awid   = ID_W'(grant);
  assign bus.m_axi_wdata  = sel_data;
  assign bus.m_axi_wstrb  = '1;
  assign bus.m_axi_wlast  = (state == ST_DATA) &&
                            (beats == 8'd0);
  assign bus.s_axi_bresp  = {NUM_CH{bus.m_axi_bresp}};

  // Unknown IDs are swallowed so the DDR side never stalls.
  always_comb begin
    b_legal          = 1'b0;
    bus.s_axi_bvalid = '0;
    bus.m_axi_bready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(bus.m_axi_bid) == i) begin
        b_legal             = 1'b1;
        bus.s_axi_bvalid[i] = bus.m_axi_bvalid;
        bus.m_axi_bready    = bus.s_axi_bready[i];
      end
    end
    if (!b_legal) bus.m_axi_bready = 1'b1;
    if (areset) begin
      bus.s_axi_bvalid = '0;
      bus.m_axi_bready = 1'b0;
    end
  end

  assign b_hs = bus.s_axi_bvalid & bus.s_axi_bready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_oh <= '0;
      ptr      <= IW'(NUM_CH - 1);
      beats    <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && arb_any) begin
        grant    <= arb_idx;
        grant_oh <= arb_gnt;
      end
      if (aw_hs) begin
        beats <= sel_len;
      end else if (w_hs && beats != 8'd0) begin
        beats <= beats - 8'd1;
      end
      if (w_done) ptr <= grant;
      if (bus.m_axi_bvalid && !b_legal) err <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (areset) begin
        outst[i] <= '0;
      end else if (aw_hs && grant_oh[i] && !b_hs[i]) begin
        if (outst[i] != CW'(MAX_OUT))
          outst[i] <= outst[i] + CW'(1);
      end else if (b_hs[i] && !(aw_hs && grant_oh[i])) begin
        if (outst[i] != '0)
          outst[i] <= outst[i] - CW'(1);
      end
    end
  end

endmodule
